// File: rtl/complete_multiplier.sv
// Digit-serial carry-less (GF(2)[x]) multiplier: captures U/V after reset release,
// folds in D bits of V per cycle (MSB digit first) and presents clmul(U,V) << 1 with a sticky done.
module complete_multiplier #(
  parameter int N = 17669,
  parameter int D = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     U,
  input  logic [N-1:0]     V,
  output logic [2*N-1:0]   W,
  output logic             done
);

  localparam int K  = (N + D - 1) / D;
  localparam int VW = K * D;
  localparam int AW = 2 * N - 1;
  localparam int CW = $clog2(K + 1);

  // The LOAD step is the exit edge of IDLE, so IDLE only persists while reset is held.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [N-1:0]    r_u;
  logic [VW-1:0]   r_v;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_w;
  logic            r_done;

  logic [D-1:0]    w_digit;
  logic [AW-1:0]   w_pp;
  logic [AW-1:0]   w_acc_next;
  logic            w_load;
  logic            w_step;
  logic            w_last;

  assign W    = r_w;
  assign done = r_done;

  // V sits in the low N bits of r_v, so the top digit picks up the zero padding.
  assign w_digit = r_v[VW-1 -: D];

  always_comb begin
    w_pp = '0;
    for (int b = 0; b < D; b++) begin
      if (w_digit[b]) w_pp = w_pp ^ (AW'(r_u) << b);
    end
  end

  assign w_acc_next = (r_acc << D) ^ w_pp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load       = 1'b1;
        w_state_next = ST_CALC;
      end
      ST_CALC: begin
        w_step = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: operand and accumulator registers are cleared too, so an aborted run leaves nothing behind.
      r_u    <= '0;
      r_v    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_w    <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_u   <= U;
        r_v   <= VW'(V);
        r_acc <= '0;
        r_cnt <= CW'(K);
      end
      if (w_step) begin
        r_v   <= r_v << D;
        r_acc <= w_acc_next;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_last) begin
        r_w    <= {w_acc_next, 1'b0};
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_complete_multiplier.sv
// Scoreboard bench for complete_multiplier: expected products are queued when operands
// are driven and compared when done rises; latency, stickiness and mid-run reset are checked.
module tb_complete_multiplier;

  localparam int N   = 17669;
  localparam int D   = 32;
  localparam int W2  = 2 * N;
  localparam int KR  = (N + 31) / 32;
  localparam int LAT = 1 + (N + D - 1) / D;

  logic            clk;
  logic            reset;
  logic [N-1:0]    U;
  logic [N-1:0]    V;
  logic [W2-1:0]   W;
  logic            done;

  int              n_total;
  int              n_bad;
  logic [W2-1:0]   exp_q[$];

  logic [N-1:0]    u_t;
  logic [N-1:0]    v_t;
  logic [W2-1:0]   e_t;

  complete_multiplier #(.N(N), .D(D)) dut (
    .clk  (clk),
    .reset(reset),
    .U    (U),
    .V    (V),
    .W    (W),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W2-1:0] got, input logic [W2-1:0] exp);
    int idx;
    n_total++;
    if (got !== exp) begin
      n_bad++;
      idx = -1;
      for (int i = 0; i < W2; i++) begin
        if (got[i] !== exp[i]) begin
          idx = i;
          break;
        end
      end
      $display("FAIL %s: got[63:0]=%h want[63:0]=%h first_diff_bit=%0d",
               tag, got[63:0], exp[63:0], idx);
    end
  endtask

  // Bit-serial LSB-first reference: shift U once per V bit and XOR where V is set.
  function automatic logic [W2-1:0] clmul_ref(input logic [N-1:0] u, input logic [N-1:0] v);
    logic [W2-1:0] acc;
    logic [W2-1:0] us;
    acc = '0;
    us  = W2'(u);
    for (int j = 0; j < N; j++) begin
      if (v[j]) acc = acc ^ us;
      us = us << 1;
    end
    return acc << 1;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [KR*32-1:0] t;
    for (int i = 0; i < KR; i++) t[i*32 +: 32] = $urandom;
    return t[N-1:0];
  endfunction

  task automatic run_case(input string tag, input logic [N-1:0] u, input logic [N-1:0] v,
                          input logic [W2-1:0] exp, input bit scramble);
    int            edges;
    bit            early_bad;
    logic [W2-1:0] want;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "/rst_w"}, W, '0);
    check({tag, "/rst_done"}, W2'(done), '0);
    @(negedge clk);
    U     = u;
    V     = v;
    reset = 1'b0;
    exp_q.push_back(exp);
    edges     = 0;
    early_bad = 1'b0;
    while (edges < LAT + 150) begin
      @(posedge clk);
      #1;
      edges++;
      if (scramble && edges == 1) begin
        U = rand_vec();
        V = rand_vec();
      end
      if (done === 1'b1) break;
      if (W !== '0) early_bad = 1'b1;
    end
    want = exp_q.pop_front();
    check({tag, "/latency"}, W2'(edges), W2'(LAT));
    check({tag, "/early_w"}, W2'(early_bad), '0);
    check({tag, "/w"}, W, want);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "/sticky_done"}, W2'(done), W2'(1));
    check({tag, "/sticky_w"}, W, want);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    U       = '0;
    V       = '0;
    #12;

    run_case("one", N'(1), N'(1), W2'(2), 1'b0);
    run_case("three", N'(3), N'(3), W2'('hA), 1'b0);
    run_case("seven_five", N'(7), N'(5), W2'('h36), 1'b0);

    u_t = '0; u_t[N-1] = 1'b1;
    e_t = '0; e_t[W2-1] = 1'b1;
    run_case("msb", u_t, u_t, e_t, 1'b0);

    run_case("zero_u", '0, '1, '0, 1'b0);
    run_case("zero_v", '1, '0, '0, 1'b0);

    u_t = '1;
    run_case("ones", u_t, u_t, clmul_ref(u_t, u_t), 1'b0);
    check("ones/w0", W2'(W[0]), '0);
    check("ones/w1", W2'(W[1]), W2'(1));

    for (int r = 0; r < 3; r++) begin
      u_t = rand_vec();
      v_t = rand_vec();
      run_case($sformatf("rand%0d", r), u_t, v_t, clmul_ref(u_t, v_t), 1'b1);
    end

    // Abort a run partway through with an asynchronous reset, then restart.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    U     = rand_vec();
    V     = rand_vec();
    reset = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("abort/pre_done", W2'(done), '0);
    #2;
    reset = 1'b1;
    #1;
    check("abort/w", W, '0);
    check("abort/done", W2'(done), '0);
    u_t = rand_vec();
    v_t = rand_vec();
    run_case("after_abort", u_t, v_t, clmul_ref(u_t, v_t), 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/complete_multiplier.md
# complete_multiplier

Sequential carry-less (GF(2)[x]) polynomial multiplier for 17669-bit operands, producing a 35338-bit product. It is the top-level multiplier block in the polynomial-multiplication datapath. It starts automatically when reset is released and flags completion with a sticky `done`. The result is bit-exact against a combinational schoolbook GF(2) reference. Product alignment: the product is shifted left by one, so `W[0]` is always 0.

## Interface
Parameters:
- `N`, 17669: operand width in bits; the product is 2*N bits wide.
- `D`, 32: digit width, i.e. the number of bits of `V` consumed per compute cycle. `N` need not be a multiple of `D`.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `U`  input  N: multiplicand; bit i is the coefficient of x^i.
- `V`  input  N: multiplier; bit j is the coefficient of x^j.
- `W`  output  2*N: registered product.
- `done`  output  1: registered; high when `W` holds the final product.

## Operation
- Function: W = clmul(U, V) << 1.
  - W[0] = 0.
  - W[k+1] = XOR over all i+j=k of (U[i] & V[j]), for k = 0 … 2N-2.
- There is no carry propagation; all additions are XOR.
- States:
  - IDLE: entered on reset.
  - LOAD: occupies the first rising edge with `reset` low. Captures `U` and `V` into internal registers, clears the accumulator, and loads the digit counter with K = ceil(N/D).
  - CALC: K cycles. Each cycle processes the next D-bit digit of the captured V, most-significant digit first. The update is acc = (acc << D) XOR (U_captured × digit). The top digit is zero-padded when N mod D ≠ 0.
  - DONE: on the last CALC edge, `W` is loaded with the final product (including the <<1 alignment) and `done` is set. The block stays in DONE until the next reset.
- Transitions: IDLE→LOAD→CALC occur unconditionally once `reset` is low; there is no start input.
- Operands are sampled only in LOAD. Changes to `U`/`V` afterwards are ignored until the next reset.
- `W` changes only at the DONE transition; it holds 0 before that. Intermediate accumulator values are never visible on `W`.

## Timing
- Reset values: `W` = 0, `done` = 0, state IDLE, accumulator and counters cleared.
- Operands must be valid at the first rising edge after `reset` falls. They may be applied in the same timestep as the `reset` deassertion.
- Latency with defaults: K = 553, so `done` rises at the 554th rising edge after reset release (1 LOAD + 553 CALC).
  - A counter incremented on each edge where `reset` is low and `done` is low reads 554.
- General latency: 1 + ceil(N/D) edges.
- `done` and `W` are sticky: both hold indefinitely until `reset` is asserted.
- Reset mid-operation: an immediate asynchronous clear to the reset values. The computation is aborted and restarts with new operands after release.
- A new multiplication requires a reset pulse of at least one clock edge.

## Test plan
- U=1, V=1 → at edge 554, W = 2 (only bit 1 set), done = 1. Before edge 554, done = 0 and W = 0.
- U=3, V=3 → W = 0xA (clmul 0b101 shifted left by 1). U=0x7, V=0x5 → W = 0x36.
- U = 2^(N-1), V = 2^(N-1) → only W[2N-1] is set. This checks the top-digit padding and the MSB alignment.
- U = 0 with V all-ones, and U all-ones with V = 0 → W = 0 with the latency still exactly 554 edges. Then U all-ones and V all-ones → W equals the schoolbook reference (check W[0]=0 and W[1]=1).
- Random 17669-bit U/V, 3 runs separated by 1-cycle reset pulses → each W matches the schoolbook reference. Changing U/V after LOAD does not alter the result.
- Assert reset at edge 300 of a run → W = 0 and done = 0 immediately (asynchronously). After release, the new operands complete in 554 edges with the correct product.
